// File: rtl/rx_fcs_checker.sv
// rx_fcs_checker: receive-side Ethernet FCS checker.
// Runs MSB-first CRC-32 (poly 0x04C11DB7, first serial bit = data[31]) over
// every byte of a frame, FCS included, and reports good/bad, byte length,
// runt and abort status with a one-cycle stat_valid pulse.
// Optional feature: define RX_FCS_STATS_EN to build the saturating
// good/bad frame counters; otherwise cnt_good/cnt_bad are tied to zero.
//
// Handshake: a beat transfers on a rising edge where in_valid && in_ready.
// in_ready is registered; it is high in IDLE and DATA and low while the
// eof word is drained byte-by-byte (TAIL) and while status is presented (DONE).
module rx_fcs_checker #(
  parameter logic [31:0] RESIDUE = 32'hC704_DD7B,
  parameter int          MIN_LEN = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic        in_sof,
  input  logic        in_eof,
  input  logic [1:0]  in_bcnt,
  output logic        stat_valid,
  output logic        stat_crc_ok,
  output logic        stat_runt,
  output logic        stat_abort,
  output logic [15:0] stat_len,
  output logic [15:0] cnt_good,
  output logic [15:0] cnt_bad
);

  localparam logic [31:0] POLY     = 32'h04C1_1DB7;
  localparam logic [31:0] CRC_INIT = 32'hFFFF_FFFF;
  localparam logic [15:0] MIN_LEN16 = 16'(MIN_LEN);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    TAIL = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t      state;
  logic [31:0] crc;
  logic [15:0] len;
  logic [31:0] tail_word;
  logic [2:0]  tail_cnt;

  logic        take;
  logic [2:0]  bcnt_n;
  logic [31:0] crc_first;
  logic [31:0] crc_word;
  logic [31:0] crc_tail;
  logic [15:0] len_word;
  logic [15:0] len_tail;

  // One byte through the CRC, most significant bit first.
  function automatic logic [31:0] crc_step8(input logic [31:0] c_in, input logic [7:0] d);
    logic [31:0] c;
    c = c_in;
    for (int i = 7; i >= 0; i--) begin
      if (c[31] ^ d[i]) c = {c[30:0], 1'b0} ^ POLY;
      else              c = {c[30:0], 1'b0};
    end
    return c;
  endfunction

  // A full word is four byte steps, lane [31:24] first.
  function automatic logic [31:0] crc_step32(input logic [31:0] c_in, input logic [31:0] d);
    return crc_step8(crc_step8(crc_step8(crc_step8(c_in, d[31:24]), d[23:16]), d[15:8]), d[7:0]);
  endfunction

  // Length addition that sticks at 16'hFFFF instead of wrapping.
  function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [2:0] inc);
    logic [16:0] s;
    s = {1'b0, a} + {14'd0, inc};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  // Next-value datapath shared by the FSM branches.
  always_comb begin
    take      = in_valid && in_ready;
    bcnt_n    = (in_bcnt == 2'd0) ? 3'd4 : {1'b0, in_bcnt};
    crc_first = crc_step32(CRC_INIT, in_data);
    crc_word  = crc_step32(crc, in_data);
    crc_tail  = crc_step8(crc, tail_word[31:24]);
    len_word  = sat_add(len, 3'd4);
    len_tail  = sat_add(len, 3'd1);
  end

  // Frame FSM with registered handshake and status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      crc         <= CRC_INIT;
      len         <= 16'd0;
      tail_word   <= 32'd0;
      tail_cnt    <= 3'd0;
      in_ready    <= 1'b1;
      stat_valid  <= 1'b0;
      stat_crc_ok <= 1'b0;
      stat_runt   <= 1'b0;
      stat_abort  <= 1'b0;
      stat_len    <= 16'd0;
    end else begin
      stat_valid <= 1'b0;
      case (state)
        IDLE, DATA: begin
          if (take) begin
            if (in_sof) begin
              // A sof while a frame is open closes that frame as aborted.
              if (state == DATA) begin
                stat_valid  <= 1'b1;
                stat_crc_ok <= 1'b0;
                stat_runt   <= (len < MIN_LEN16);
                stat_abort  <= 1'b1;
                stat_len    <= len;
              end
              if (in_eof) begin
                // Single-beat frame: all its bytes go through the byte path.
                crc       <= CRC_INIT;
                len       <= 16'd0;
                tail_word <= in_data;
                tail_cnt  <= bcnt_n;
                in_ready  <= 1'b0;
                state     <= TAIL;
              end else begin
                crc   <= crc_first;
                len   <= 16'd4;
                state <= DATA;
              end
            end else if (state == DATA) begin
              if (in_eof) begin
                tail_word <= in_data;
                tail_cnt  <= bcnt_n;
                in_ready  <= 1'b0;
                state     <= TAIL;
              end else begin
                crc <= crc_word;
                len <= len_word;
              end
            end
            // Non-sof beats in IDLE are dropped.
          end
        end
        TAIL: begin
          crc       <= crc_tail;
          len       <= len_tail;
          tail_word <= {tail_word[23:0], 8'h00};
          tail_cnt  <= tail_cnt - 3'd1;
          if (tail_cnt == 3'd1) begin
            // Status is formed from the post-last-byte values so it is
            // presented during the DONE cycle.
            stat_valid  <= 1'b1;
            stat_crc_ok <= (crc_tail == RESIDUE);
            stat_runt   <= (len_tail < MIN_LEN16);
            stat_abort  <= 1'b0;
            stat_len    <= len_tail;
            state       <= DONE;
          end
        end
        DONE: begin
          in_ready <= 1'b1;
          state    <= IDLE;
        end
        default: begin
          in_ready <= 1'b1;
          state    <= IDLE;
        end
      endcase
    end
  end

`ifdef RX_FCS_STATS_EN
  // Saturating frame counters, updated from the registered status pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_good <= 16'd0;
      cnt_bad  <= 16'd0;
    end else if (stat_valid) begin
      if (stat_crc_ok && !stat_runt && !stat_abort) begin
        if (cnt_good != 16'hFFFF) cnt_good <= cnt_good + 16'd1;
      end else begin
        if (cnt_bad != 16'hFFFF) cnt_bad <= cnt_bad + 16'd1;
      end
    end
  end
`else
  assign cnt_good = 16'd0;
  assign cnt_bad  = 16'd0;
`endif

endmodule

// File: tb/tb_rx_fcs_checker.sv
// Testbench for rx_fcs_checker: directed frames with FCS produced by a
// table-driven CRC-32 model, a status scoreboard, and a final report.
module tb_rx_fcs_checker;

  localparam int W = 19;  // {crc_ok, runt, abort, len[15:0]}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT ----------------
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = 32'd0;
  logic        in_sof = 1'b0;
  logic        in_eof = 1'b0;
  logic [1:0]  in_bcnt = 2'd0;
  logic        stat_valid;
  logic        stat_crc_ok;
  logic        stat_runt;
  logic        stat_abort;
  logic [15:0] stat_len;
  logic [15:0] cnt_good;
  logic [15:0] cnt_bad;

  rx_fcs_checker dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_sof      (in_sof),
    .in_eof      (in_eof),
    .in_bcnt     (in_bcnt),
    .stat_valid  (stat_valid),
    .stat_crc_ok (stat_crc_ok),
    .stat_runt   (stat_runt),
    .stat_abort  (stat_abort),
    .stat_len    (stat_len),
    .cnt_good    (cnt_good),
    .cnt_bad     (cnt_bad)
  );

  // ---------------- checking ----------------
  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- CRC model (table driven) ----------------
  logic [31:0] crc_tbl [256];
  logic [7:0]  fb [0:255];

  task automatic init_tbl();
    logic [31:0] c;
    for (int i = 0; i < 256; i++) begin
      c = 32'(i) << 24;
      for (int k = 0; k < 8; k++) c = c[31] ? ((c << 1) ^ 32'h04C1_1DB7) : (c << 1);
      crc_tbl[i] = c;
    end
  endtask

  // Fill fb with L-4 payload bytes followed by the complemented CRC, MSB byte first.
  task automatic build_frame(input int L, input int seed);
    logic [31:0] c;
    logic [7:0]  b;
    c = 32'hFFFF_FFFF;
    for (int i = 0; i < L - 4; i++) begin
      b = 8'(i * 37 + seed * 11 + 5);
      fb[i] = b;
      c = (c << 8) ^ crc_tbl[c[31:24] ^ b];
    end
    c = ~c;
    fb[L-4] = c[31:24];
    fb[L-3] = c[23:16];
    fb[L-2] = c[15:8];
    fb[L-1] = c[7:0];
  endtask

  function automatic logic [31:0] frame_word(input int L, input int j);
    logic [31:0] w;
    w = 32'd0;
    for (int k = 0; k < 4; k++)
      if (4 * j + k < L) w[31 - 8*k -: 8] = fb[4*j + k];
    return w;
  endfunction

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q [$];
  int           exp_cyc_q [$];
  int           exp_good = 0;
  int           exp_bad = 0;

  task automatic push_exp(input logic ok, input logic runt, input logic abrt,
                          input logic [15:0] len, input int at_cyc);
    exp_q.push_back({ok, runt, abrt, len});
    exp_cyc_q.push_back(at_cyc);
    if (ok && !runt && !abrt) exp_good++;
    else exp_bad++;
  endtask

  always @(negedge clk) begin
    logic [W-1:0] e;
    int ec;
    if (rst_n && stat_valid) begin
      if (exp_q.size() == 0) begin
        chk("extra_pulse", 32'd1, 32'd0);
      end else begin
        e  = exp_q.pop_front();
        ec = exp_cyc_q.pop_front();
        chk("crc_ok",  {31'd0, stat_crc_ok}, {31'd0, e[18]});
        chk("runt",    {31'd0, stat_runt},   {31'd0, e[17]});
        chk("abort",   {31'd0, stat_abort},  {31'd0, e[16]});
        chk("len",     {16'd0, stat_len},    {16'd0, e[15:0]});
        chk("latency", 32'(cyc),             32'(ec));
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called at posedge+1; returns at posedge+1 after the transfer edge.
  task automatic drive_beat(input logic [31:0] d, input logic s, input logic e,
                            input logic [1:0] b, output int acc);
    in_valid = 1'b1;
    in_data  = d;
    in_sof   = s;
    in_eof   = e;
    in_bcnt  = b;
    acc = -1;
    for (int t = 0; t < 50 && acc < 0; t++) begin
      @(negedge clk);
      if (in_ready) acc = cyc;
      @(posedge clk);
      #1;
    end
    if (acc < 0) chk("beat_timeout", 32'd0, 32'd1);
  endtask

  // First nb beats of a frame, no eof; in_valid left asserted.
  task automatic send_partial(input int L, input int seed, input int nb);
    int acc;
    build_frame(L, seed);
    for (int j = 0; j < nb; j++) drive_beat(frame_word(L, j), j == 0, 1'b0, 2'd0, acc);
  endtask

  // Complete frame; optional bit flip in one beat; optional expected abort of
  // a previously opened frame of abort_len bytes.
  task automatic send_frame(input int L, input int seed, input int flip_beat, input int abort_len);
    int acc;
    int nb;
    int n;
    int lows;
    logic [31:0] w;
    logic e;
    build_frame(L, seed);
    nb = (L + 3) / 4;
    n  = (L % 4 == 0) ? 4 : L % 4;
    for (int j = 0; j < nb; j++) begin
      w = frame_word(L, j);
      if (j == flip_beat) w = w ^ 32'd1;
      e = (j == nb - 1);
      drive_beat(w, j == 0, e, e ? 2'(L % 4) : 2'd0, acc);
      if (j == 0 && abort_len >= 0)
        push_exp(1'b0, abort_len < 64, 1'b1, 16'(abort_len), acc + 1);
      if (e)
        push_exp(flip_beat < 0, L < 64, 1'b0, 16'(L), acc + n + 1);
    end
    in_valid = 1'b0;
    in_sof   = 1'b0;
    in_eof   = 1'b0;
    lows = 0;
    for (int i = 0; i <= n; i++) begin
      @(negedge clk);
      if (!in_ready) lows++;
    end
    chk("ready_low", 32'(lows), 32'(n + 1));
    @(negedge clk);
    chk("ready_back", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic drain_and_count();
    for (int t = 0; t < 40 && exp_q.size() != 0; t++) @(negedge clk);
    chk("drain", 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    #1;
`ifdef RX_FCS_STATS_EN
    chk("cnt_good", {16'd0, cnt_good}, 32'(exp_good));
    chk("cnt_bad",  {16'd0, cnt_bad},  32'(exp_bad));
`else
    chk("cnt_good", {16'd0, cnt_good}, 32'd0);
    chk("cnt_bad",  {16'd0, cnt_bad},  32'd0);
`endif
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_ready"},  {31'd0, in_ready},    32'd1);
    chk({tag, "_valid"},  {31'd0, stat_valid},  32'd0);
    chk({tag, "_crc_ok"}, {31'd0, stat_crc_ok}, 32'd0);
    chk({tag, "_runt"},   {31'd0, stat_runt},   32'd0);
    chk({tag, "_abort"},  {31'd0, stat_abort},  32'd0);
    chk({tag, "_len"},    {16'd0, stat_len},    32'd0);
    chk({tag, "_good"},   {16'd0, cnt_good},    32'd0);
    chk({tag, "_bad"},    {16'd0, cnt_bad},     32'd0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int acc;
    init_tbl();
    repeat (3) @(negedge clk);
    check_reset_values("rst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Stray non-sof beat in IDLE is dropped without status.
    drive_beat(32'hDEAD_BEEF, 1'b0, 1'b1, 2'd0, acc);
    in_valid = 1'b0;
    repeat (8) @(negedge clk);
    chk("stray_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;

    // Good 64-byte frame.
    send_frame(64, 1, -1, -1);
    drain_and_count();

    // Same frame with bit 0 of beat 5 flipped.
    send_frame(64, 1, 5, -1);
    drain_and_count();

    // Odd tail lengths.
    send_frame(65, 2, -1, -1);
    send_frame(66, 3, -1, -1);
    send_frame(67, 4, -1, -1);
    drain_and_count();

    // Runt with good FCS.
    send_frame(60, 5, -1, -1);
    drain_and_count();

    // Abort: sof arrives as beat 8 of an open frame.
    send_partial(64, 6, 7);
    send_frame(64, 7, -1, 28);
    drain_and_count();

    // Reset in the middle of a frame (beat 10).
    send_partial(64, 8, 9);
    in_valid = 1'b0;
    in_sof   = 1'b0;
    rst_n    = 1'b0;
    exp_good = 0;
    exp_bad  = 0;
    repeat (2) @(negedge clk);
    check_reset_values("midrst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    send_frame(64, 9, -1, -1);
    drain_and_count();

    repeat (4) @(posedge clk);
    chk("pending", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
